// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets,
// TCTRL bit positions and the address-decode region type.
package dmem_pkg;

  localparam logic [3:0] OFF_CYCLE = 4'h0;
  localparam logic [3:0] OFF_LED   = 4'h1;
  localparam logic [3:0] OFF_TCMP  = 4'h2;
  localparam logic [3:0] OFF_TCTRL = 4'h3;
  localparam logic [3:0] OFF_TCNT  = 4'h4;

  localparam int EN   = 0;
  localparam int FLAG = 1;
  localparam int AUTO = 2;

  localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_NONE
  } region_e;

  function automatic logic [31:0] tctrl_pack(input logic en, input logic flag,
                                             input logic auto_rl);
    logic [31:0] v;
    v       = '0;
    v[EN]   = en;
    v[FLAG] = flag;
    v[AUTO] = auto_rl;
    return v;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Processor data-memory port: word address, write data/enable, registered read data.
interface dmem_responder_if;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;

  modport master (output address_dmem, output data, output wren, input q_dmem);
  modport slave  (input address_dmem, input data, input wren, output q_dmem);
endinterface

// File: rtl/dmem_responder_mmio_timer.sv
// Compare timer: counts while enabled, sets a sticky flag on TCNT == TCMP,
// then either reloads (AUTO) or stops (one-shot).
module mmio_timer
  import dmem_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_cmp_we,
  input  logic        i_ctrl_we,
  input  logic [31:0] i_wdata,
  output logic        o_flag,
  output logic [31:0] o_cnt,
  output logic [31:0] o_cmp,
  output logic [31:0] o_ctrl
);

  logic [31:0] r_cnt;
  logic [31:0] r_cmp;
  logic        r_en;
  logic        r_flag;
  logic        r_auto;

  logic w_match;
  logic w_en_rise;

  // The compare always sees the pre-edge TCMP, so a same-edge TCMP write
  // only takes effect from the following edge.
  assign w_match   = r_en && (r_cnt == r_cmp);
  assign w_en_rise = i_ctrl_we && i_wdata[EN] && !r_en;

  // NOTE: every state register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_cmp  <= TCMP_RST;
      r_en   <= 1'b0;
      r_flag <= 1'b0;
      r_auto <= 1'b0;
    end else begin
      if (i_cmp_we) r_cmp <= i_wdata;

      if (w_en_rise)    r_cnt <= '0;
      else if (w_match) begin
        if (r_auto) r_cnt <= '0;
      end
      else if (r_en)    r_cnt <= r_cnt + 32'd1;

      if (w_match && !r_auto) r_en <= 1'b0;
      else if (i_ctrl_we)     r_en <= i_wdata[EN];

      if (i_ctrl_we) r_auto <= i_wdata[AUTO];

      // A match outranks a same-edge write-1-to-clear.
      if (w_match)                         r_flag <= 1'b1;
      else if (i_ctrl_we && i_wdata[FLAG]) r_flag <= 1'b0;
    end
  end

  assign o_flag = r_flag;
  assign o_cnt  = r_cnt;
  assign o_cmp  = r_cmp;
  assign o_ctrl = tctrl_pack(r_en, r_flag, r_auto);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus a 16-word MMIO window (cycle counter,
// LED register, compare timer). Read data is registered with one cycle latency.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_BITS = 12,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FFF0,
  parameter int          LED_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  dmem_responder_if.slave  bus,
  output logic [LED_W-1:0] leds,
  output logic             timer_irq,
  output logic             bus_err
);

  region_e                w_region;
  logic [3:0]             w_off;
  logic [ADDR_BITS-1:0]   w_ram_idx;
  logic                   w_ram_we;
  logic                   w_mmio_we;
  logic [31:0]            w_mmio_rdata;
  logic [31:0]            w_cnt;
  logic [31:0]            w_cmp;
  logic [31:0]            w_ctrl;
  logic                   w_flag;

  logic [31:0]            r_mem [2**ADDR_BITS];
  logic [31:0]            r_ram_q;
  logic                   r_sel_ram;
  logic [31:0]            r_mmio_q;
  logic [31:0]            r_cycle;
  logic [LED_W-1:0]       r_led;
  logic                   r_bus_err;

  assign w_off     = bus.address_dmem[3:0];
  assign w_ram_idx = bus.address_dmem[ADDR_BITS-1:0];

  always_comb begin
    w_region = REGION_NONE;
    if (bus.address_dmem[31:ADDR_BITS] == '0)
      w_region = REGION_RAM;
    else if (bus.address_dmem[31:4] == MMIO_BASE[31:4])
      w_region = REGION_MMIO;
  end

  assign w_ram_we  = bus.wren && (w_region == REGION_RAM);
  assign w_mmio_we = bus.wren && (w_region == REGION_MMIO);

  // NOTE: the RAM array is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (w_ram_we) r_mem[w_ram_idx] <= bus.data;
    r_ram_q <= r_mem[w_ram_idx];
  end

  mmio_timer u_timer (
    .clock     (clock),
    .reset     (reset),
    .i_cmp_we  (w_mmio_we && (w_off == OFF_TCMP)),
    .i_ctrl_we (w_mmio_we && (w_off == OFF_TCTRL)),
    .i_wdata   (bus.data),
    .o_flag    (w_flag),
    .o_cnt     (w_cnt),
    .o_cmp     (w_cmp),
    .o_ctrl    (w_ctrl)
  );

  // NOTE: the default ahead of the case keeps this block free of inferred latches.
  always_comb begin
    w_mmio_rdata = '0;
    case (w_off)
      OFF_CYCLE: w_mmio_rdata = r_cycle;
      OFF_LED:   w_mmio_rdata = 32'(r_led);
      OFF_TCMP:  w_mmio_rdata = w_cmp;
      OFF_TCTRL: w_mmio_rdata = w_ctrl;
      OFF_TCNT:  w_mmio_rdata = w_cnt;
      default:   w_mmio_rdata = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sel_ram <= 1'b0;
      r_mmio_q  <= '0;
      r_cycle   <= '0;
      r_led     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_sel_ram <= (w_region == REGION_RAM);
      r_mmio_q  <= (w_region == REGION_MMIO) ? w_mmio_rdata : '0;
      r_cycle   <= r_cycle + 32'd1;
      if (w_mmio_we && (w_off == OFF_LED)) r_led <= bus.data[LED_W-1:0];
      if (w_region == REGION_NONE) r_bus_err <= 1'b1;
    end
  end

  // The RAM word comes from its own register; r_sel_ram resets low so q_dmem reads 0.
  assign bus.q_dmem = r_sel_ram ? r_ram_q : r_mmio_q;
  assign leds       = r_led;
  assign timer_irq  = w_flag;
  assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table for RAM/MMIO access,
// hand-written sequences for the timer, unmapped access and async reset.
module tb_dmem_responder;

  localparam logic [31:0] A_CYCLE = 32'hFFFF_FFF0;
  localparam logic [31:0] A_LED   = 32'hFFFF_FFF1;
  localparam logic [31:0] A_TCMP  = 32'hFFFF_FFF2;
  localparam logic [31:0] A_TCTRL = 32'hFFFF_FFF3;
  localparam logic [31:0] A_TCNT  = 32'hFFFF_FFF4;
  localparam logic [31:0] A_RSVD  = 32'hFFFF_FFF5;
  localparam logic [31:0] A_UNMAP = 32'h0001_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] leds;
  logic        timer_irq;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] value;
    string       name;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  dmem_responder_if bus ();

  dmem_responder #(
    .ADDR_BITS (12),
    .MMIO_BASE (32'hFFFF_FFF0),
    .LED_W     (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .leds      (leds),
    .timer_irq (timer_irq),
    .bus_err   (bus_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Drive one access, queue its expected read data, and compare one edge later.
  task automatic cycle(input logic [31:0] addr, input logic [31:0] wd, input logic we,
                       input logic chk, input logic [31:0] exp, input string name);
    exp_t e;
    bus.address_dmem = addr;
    bus.data         = wd;
    bus.wren         = we;
    if (chk) sb.push_back('{exp, name});
    @(posedge clock);
    #1;
    bus.wren         = 1'b0;
    bus.address_dmem = '0;
    if (chk) begin
      e = sb.pop_front();
      check(e.name, bus.q_dmem, e.value);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    cycle(addr, wd, 1'b1, 1'b0, '0, "wr");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    cycle(addr, '0, 1'b0, 1'b1, exp, name);
  endtask

  initial begin
    vecs = '{
      '{32'h0000_0000, 32'h1111_1111, 1'b1, 1'b0, 32'h0},
      '{A_TCMP,        32'h0,         1'b0, 1'b1, 32'hFFFF_FFFF},
      '{A_TCTRL,       32'h0,         1'b0, 1'b1, 32'h0},
      '{32'h0000_0005, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0},
      '{32'h0000_0005, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF},
      '{32'h0000_0005, 32'h0000_0001, 1'b1, 1'b1, 32'hDEAD_BEEF},
      '{32'h0000_0005, 32'h0,         1'b0, 1'b1, 32'h0000_0001},
      '{A_LED,         32'h0001_A5A5, 1'b1, 1'b0, 32'h0},
      '{A_LED,         32'h0,         1'b0, 1'b1, 32'h0000_A5A5},
      '{A_TCMP,        32'h1234_5678, 1'b1, 1'b0, 32'h0},
      '{A_TCMP,        32'h0,         1'b0, 1'b1, 32'h1234_5678},
      '{A_TCNT,        32'h0000_00AA, 1'b1, 1'b0, 32'h0},
      '{A_TCNT,        32'h0,         1'b0, 1'b1, 32'h0},
      '{A_RSVD,        32'hCAFE_F00D, 1'b1, 1'b0, 32'h0},
      '{A_RSVD,        32'h0,         1'b0, 1'b1, 32'h0},
      '{A_TCTRL,       32'hFFFF_FFF8, 1'b1, 1'b0, 32'h0},
      '{A_TCTRL,       32'h0,         1'b0, 1'b1, 32'h0}
    };

    bus.address_dmem = '0;
    bus.data         = '0;
    bus.wren         = 1'b0;

    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_q",   bus.q_dmem, 32'h0);
    check("rst_led", 32'(leds), 32'h0);
    check("rst_irq", 32'(timer_irq), 32'h0);
    check("rst_err", 32'(bus_err), 32'h0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++)
      cycle(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].chk, vecs[i].exp,
            $sformatf("vec%0d", i));
    check("led_out", 32'(leds), 32'h0000_A5A5);
    check("err_idle", 32'(bus_err), 32'h0);

    // One-shot timer: TCMP = 3, enable, flag four edges after the enable write.
    wr(A_TCMP, 32'd3);
    wr(A_TCTRL, 32'h1);
    rd(A_TCNT, 32'd0, "os_cnt0");
    rd(A_TCNT, 32'd1, "os_cnt1");
    rd(A_TCNT, 32'd2, "os_cnt2");
    check("os_irq_early", 32'(timer_irq), 32'h0);
    rd(A_TCNT, 32'd3, "os_cnt3");
    check("os_irq_set", 32'(timer_irq), 32'h1);
    rd(A_TCTRL, 32'h2, "os_ctrl");
    rd(A_TCNT, 32'd3, "os_cnt_hold");
    wr(A_TCTRL, 32'h2);
    check("os_irq_clr", 32'(timer_irq), 32'h0);
    rd(A_TCTRL, 32'h0, "os_ctrl_clr");

    // Auto-reload with TCMP = 2: TCNT runs 0,1,2; W1C on the match edge loses.
    wr(A_TCMP, 32'd2);
    wr(A_TCTRL, 32'h5);
    rd(A_TCNT, 32'd0, "ar_cnt0");
    rd(A_TCNT, 32'd1, "ar_cnt1");
    rd(A_TCNT, 32'd2, "ar_cnt2");
    check("ar_irq_set", 32'(timer_irq), 32'h1);
    wr(A_TCTRL, 32'h7);
    check("ar_irq_w1c", 32'(timer_irq), 32'h0);
    rd(A_TCNT, 32'd1, "ar_cnt_keep");
    wr(A_TCTRL, 32'h7);
    check("ar_irq_race", 32'(timer_irq), 32'h1);
    rd(A_TCNT, 32'd0, "ar_cnt_r0");
    rd(A_TCNT, 32'd1, "ar_cnt_r1");
    rd(A_TCNT, 32'd2, "ar_cnt_r2");
    rd(A_TCNT, 32'd0, "ar_cnt_r3");
    rd(A_TCNT, 32'd1, "ar_cnt_r4");
    wr(A_TCMP, 32'd5);
    rd(A_TCNT, 32'd0, "ar_cmp_old");
    wr(A_TCTRL, 32'h2);
    check("ar_irq_off", 32'(timer_irq), 32'h0);

    // Unmapped access: reads 0, write dropped, sticky error.
    cycle(A_UNMAP, 32'h5555_5555, 1'b1, 1'b1, 32'h0, "um_wr_q");
    check("um_err", 32'(bus_err), 32'h1);
    rd(A_UNMAP, 32'h0, "um_rd_q");
    rd(32'h0, 32'h1111_1111, "um_ram0");
    rd(32'h5, 32'h0000_0001, "um_ram5");
    check("um_err_sticky", 32'(bus_err), 32'h1);

    // Async reset mid-count, then CYCLE reads 0 on the first edge after release.
    wr(A_TCMP, 32'd100);
    wr(A_TCTRL, 32'h1);
    repeat (3) cycle(32'h0, 32'h0, 1'b0, 1'b0, '0, "idle");
    rd(32'h5, 32'h0000_0001, "pre_rst_q");
    #2 reset = 1'b0;
    #1;
    check("arst_q",   bus.q_dmem, 32'h0);
    check("arst_led", 32'(leds), 32'h0);
    check("arst_err", 32'(bus_err), 32'h0);
    check("arst_irq", 32'(timer_irq), 32'h0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    rd(A_CYCLE, 32'd0, "post_cycle0");
    rd(A_CYCLE, 32'd1, "post_cycle1");
    rd(A_TCNT,  32'd0, "post_tcnt");
    rd(A_TCTRL, 32'h0, "post_tctrl");
    rd(A_TCMP,  32'hFFFF_FFFF, "post_tcmp");
    rd(A_LED,   32'h0, "post_led");
    rd(32'h5,   32'h0000_0001, "post_ram5");

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
